imuldiv_div_frontend: RTL and testbench
=======================================

Name: imuldiv_div_frontend

Overview:
Request-side initiator and response-side consumer of the iterative divider's val/rdy protocol. Accepts a 32-bit PARC divide/remainder operation from the muldiv issue stage and drives divreq_* to the divider. It then consumes the 64-bit divresp, selects quotient or remainder, and returns a 32-bit result on its own val/rdy interface. Divide-by-zero is resolved locally without using the divider.

Parameters:
BYPASS_DIV0, 1, 1 = resolve b==0 locally; 0 = forward b==0 to the divider like any operand
CNT_W, 16, width of the completed-operation counter

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
muldivreq_msg_fn  input  2  0=DIV, 1=DIVU, 2=REM, 3=REMU
muldivreq_msg_a  input  32  dividend
muldivreq_msg_b  input  32  divisor
muldivreq_val  input  1  upstream request valid
muldivreq_rdy  output  1  upstream request ready
divreq_msg_fn  output  1  to divider: 0=signed, 1=unsigned
divreq_msg_a  output  32  to divider: dividend
divreq_msg_b  output  32  to divider: divisor
divreq_val  output  1  divider request valid
divreq_rdy  input  1  divider request ready
divresp_msg_result  input  64  from divider: {remainder[63:32], quotient[31:0]}
divresp_val  input  1  divider response valid
divresp_rdy  output  1  divider response ready
muldivresp_msg_result  output  32  selected result
muldivresp_val  output  1  result valid
muldivresp_rdy  input  1  downstream ready
ops_done  output  CNT_W  count of completed result handshakes

Behaviour:
- Interface clocking: one clock, clk; reset is synchronous and active-high.
- Registers: fn_reg[1:0], a_reg, b_reg, result_reg[31:0], state[1:0], ops_done.
- FSM states: IDLE, ISSUE, WAIT, RESP. All handshake outputs decode from state only (no input-to-output combinational paths).
  - muldivreq_rdy = IDLE.
  - divreq_val = ISSUE.
  - divresp_rdy = WAIT or IDLE.
  - muldivresp_val = RESP.
- Reset values:
  - state = IDLE, so after reset muldivreq_rdy=1, divreq_val=0, muldivresp_val=0, divresp_rdy=1.
  - result_reg = 0 and ops_done = 0.
  - divreq_msg_* and muldivresp_msg_result show their registers (0 after reset).
- IDLE:
  - On muldivreq_val&&rdy, latch fn, a, b.
  - If BYPASS_DIV0 and b==0, go to RESP. Result_reg = 32'hFFFFFFFF for DIV/DIVU; result_reg = a for REM/REMU.
  - Otherwise go to ISSUE.
  - Any divresp_val seen in IDLE is a stale response: consume it and discard it.
- ISSUE:
  - divreq_msg_fn = fn_reg[0]; divreq_msg_a = a_reg; divreq_msg_b = b_reg.
  - Hold all three stable while divreq_val=1 and divreq_rdy=0.
  - On divreq_rdy, go to WAIT.
- WAIT:
  - On divresp_val, result_reg = fn_reg[1] ? divresp_msg_result[63:32] : divresp_msg_result[31:0], then go to RESP.
- RESP:
  - Hold muldivresp_msg_result = result_reg stable until muldivresp_rdy.
  - On muldivresp_rdy, ops_done increments (wraps at 2^CNT_W) and state goes to IDLE.
  - No new request is accepted in RESP.
- Latency with a single-cycle-response divider and all readies high:
  - accept at cycle 0, divreq_val at cycle 1, response captured at cycle 2, muldivresp_val at cycle 3.
  - Div0 bypass: muldivresp_val at cycle 1.
  - Throughput: one operation in flight; next accept no earlier than the cycle after the RESP handshake.
- Arithmetic: no sign fix-up in this block; the signed result comes from the divider. 0x80000000 / -1 passes through unchanged (the divider yields 0x80000000, remainder 0).
- Reset asserted mid-operation: state returns to IDLE next edge and the in-flight operation is dropped. A divider response that arrives later is drained in IDLE. No muldivresp is produced for the dropped operation.

Test Plan:
- DIVU a=100, b=7, divider returns {2,14} -> muldivresp_msg_result=14. muldivresp_val at cycle 3. ops_done=1.
- REM a=-7 (0xFFFFFFF9), b=2, divider returns {0xFFFFFFFF,0xFFFFFFFD} -> result 0xFFFFFFFF; divreq_msg_fn=0.
- DIV b=0, a=5, BYPASS_DIV0=1 -> result 0xFFFFFFFF at cycle 1, divreq_val never asserted. REMU b=0, a=5 -> result 5.
- Backpressure: divreq_rdy low for 4 cycles, then muldivresp_rdy low for 3 cycles -> divreq_msg_* and muldivresp_msg_result stable throughout; muldivreq_rdy=0 until after the RESP handshake; exactly one divreq handshake.
- Reset asserted in WAIT, then divider asserts divresp_val 2 cycles later -> response consumed (divresp_rdy=1), muldivresp_val stays 0, ops_done=0. A following DIVU 9/3 returns 3.
- Back-to-back 3 requests with all readies high -> results in order, each 4 cycles apart, ops_done=3.

Source files
------------

// File: rtl/imuldiv_div_frontend.sv
// rtl/imuldiv_div_frontend.sv - divide/remainder front end between the muldiv issue stage and the iterative divider
// Handshake outputs decode from the registered state only; divide-by-zero can be resolved without the divider.
module imuldiv_div_frontend #(
  parameter int BYPASS_DIV0 = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       muldivreq_msg_fn,
  input  logic [31:0]      muldivreq_msg_a,
  input  logic [31:0]      muldivreq_msg_b,
  input  logic             muldivreq_val,
  output logic             muldivreq_rdy,
  output logic             divreq_msg_fn,
  output logic [31:0]      divreq_msg_a,
  output logic [31:0]      divreq_msg_b,
  output logic             divreq_val,
  input  logic             divreq_rdy,
  input  logic [63:0]      divresp_msg_result,
  input  logic             divresp_val,
  output logic             divresp_rdy,
  output logic [31:0]      muldivresp_msg_result,
  output logic             muldivresp_val,
  input  logic             muldivresp_rdy,
  output logic [CNT_W-1:0] ops_done
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state_q, state_d;
  logic [1:0]         fn_q, fn_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic [31:0]        result_q, result_d;
  logic [CNT_W-1:0]   ops_done_q, ops_done_d;

  always_comb begin
    state_d    = state_q;
    fn_d       = fn_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    ops_done_d = ops_done_q;
    case (state_q)
      IDLE: begin
        if (muldivreq_val) begin
          fn_d = muldivreq_msg_fn;
          a_d  = muldivreq_msg_a;
          b_d  = muldivreq_msg_b;
          // fn[1] selects remainder: x/0 gives all ones, x%0 gives the dividend
          if ((BYPASS_DIV0 != 0) && (muldivreq_msg_b == 32'd0)) begin
            result_d = muldivreq_msg_fn[1] ? muldivreq_msg_a : 32'hFFFF_FFFF;
            state_d  = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (divreq_rdy) state_d = WAIT;
      end
      WAIT: begin
        if (divresp_val) begin
          result_d = fn_q[1] ? divresp_msg_result[63:32] : divresp_msg_result[31:0];
          state_d  = RESP;
        end
      end
      RESP: begin
        if (muldivresp_rdy) begin
          ops_done_d = ops_done_q + CNT_W'(1);
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      fn_q       <= 2'd0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      result_q   <= 32'd0;
      ops_done_q <= '0;
    end else begin
      state_q    <= state_d;
      fn_q       <= fn_d;
      a_q        <= a_d;
      b_q        <= b_d;
      result_q   <= result_d;
      ops_done_q <= ops_done_d;
    end
  end

  // Responses arriving in IDLE belong to a dropped operation and are drained.
  assign muldivreq_rdy         = (state_q == IDLE);
  assign divreq_val            = (state_q == ISSUE);
  assign divresp_rdy           = (state_q == WAIT) || (state_q == IDLE);
  assign muldivresp_val        = (state_q == RESP);
  assign divreq_msg_fn         = fn_q[0];
  assign divreq_msg_a          = a_q;
  assign divreq_msg_b          = b_q;
  assign muldivresp_msg_result = result_q;
  assign ops_done              = ops_done_q;

endmodule

// File: tb/tb_imuldiv_div_frontend.sv
// tb/tb_imuldiv_div_frontend.sv - scoreboard bench for imuldiv_div_frontend with a behavioural divider
module tb_imuldiv_div_frontend;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  muldivreq_msg_fn = 2'd0;
  logic [31:0] muldivreq_msg_a = 32'd0;
  logic [31:0] muldivreq_msg_b = 32'd0;
  logic        muldivreq_val = 1'b0;
  logic        muldivreq_rdy;
  logic        divreq_msg_fn;
  logic [31:0] divreq_msg_a;
  logic [31:0] divreq_msg_b;
  logic        divreq_val;
  logic        divreq_rdy = 1'b1;
  logic [63:0] divresp_msg_result = 64'd0;
  logic        divresp_val = 1'b0;
  logic        divresp_rdy;
  logic [31:0] muldivresp_msg_result;
  logic        muldivresp_val;
  logic        muldivresp_rdy = 1'b1;
  logic [15:0] ops_done;

  imuldiv_div_frontend #(.BYPASS_DIV0(1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .muldivreq_msg_fn(muldivreq_msg_fn), .muldivreq_msg_a(muldivreq_msg_a),
    .muldivreq_msg_b(muldivreq_msg_b), .muldivreq_val(muldivreq_val), .muldivreq_rdy(muldivreq_rdy),
    .divreq_msg_fn(divreq_msg_fn), .divreq_msg_a(divreq_msg_a), .divreq_msg_b(divreq_msg_b),
    .divreq_val(divreq_val), .divreq_rdy(divreq_rdy),
    .divresp_msg_result(divresp_msg_result), .divresp_val(divresp_val), .divresp_rdy(divresp_rdy),
    .muldivresp_msg_result(muldivresp_msg_result), .muldivresp_val(muldivresp_val),
    .muldivresp_rdy(muldivresp_rdy), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  int          acc_q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          req_fires = 0;
  int          resp_delay = 0;
  logic [1:0]  last_fn = 2'd0;
  logic [31:0] last_a = 32'd0;
  logic [31:0] last_b = 32'd0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] div_model(input logic fn_u, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (fn_u) begin
      q = a / b; r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = 32'd0;
    end else begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end
    return {r, q};
  endfunction

  // Behavioural divider, sampled shortly after the falling edge so stimulus has settled.
  logic        drop_resp = 1'b0;
  logic        have_resp = 1'b0;
  int          resp_cnt = 0;
  logic [63:0] resp_data = 64'd0;
  always begin
    @(negedge clk); #2;
    if (drop_resp) divresp_val = 1'b0;
    drop_resp = divresp_val && divresp_rdy;
    if (have_resp && !divresp_val) begin
      if (resp_cnt == 0) begin
        divresp_val = 1'b1; divresp_msg_result = resp_data; have_resp = 1'b0;
      end else begin
        resp_cnt--;
      end
    end
    if (divreq_val && divreq_rdy) begin
      resp_data = div_model(divreq_msg_fn, divreq_msg_a, divreq_msg_b);
      if (resp_delay == 0 && !divresp_val) begin
        divresp_val = 1'b1; divresp_msg_result = resp_data;
      end else begin
        have_resp = 1'b1; resp_cnt = resp_delay;
      end
    end
  end

  // Monitor: request-side forwarding checks and scoreboard pops on result handshakes.
  logic val_seen = 1'b0;
  int   start_cyc = 0;
  always begin
    exp_t e;
    int   a0;
    @(negedge clk); #2;
    if (reset) begin
      acc_q.delete();
      val_seen = 1'b0;
    end else begin
      if (muldivreq_val && muldivreq_rdy) acc_q.push_back(cyc);
      if (divreq_val) begin
        chk("divreq_fn", 64'(divreq_msg_fn), 64'(last_fn[0]));
        chk("divreq_a", 64'(divreq_msg_a), 64'(last_a));
        chk("divreq_b", 64'(divreq_msg_b), 64'(last_b));
      end
      if (divreq_val && divreq_rdy) req_fires++;
      if (muldivresp_val && !val_seen) begin
        val_seen = 1'b1; start_cyc = cyc;
      end
      if (muldivresp_val && muldivresp_rdy) begin
        val_seen = 1'b0;
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_resp: got 0x%0h, expected no response", muldivresp_msg_result);
        end else begin
          e  = exp_q.pop_front();
          a0 = (acc_q.size() > 0) ? acc_q.pop_front() : start_cyc;
          chk("result", 64'(muldivresp_msg_result), 64'(e.res));
          if (e.lat >= 0) chk("latency", 64'(start_cyc - a0), 64'(e.lat));
        end
      end
    end
  end

  task automatic send(input logic [1:0] fn, input logic [31:0] a, input logic [31:0] b, output int acc);
    int n = 0;
    while (!muldivreq_rdy && n < 50) begin @(negedge clk); n++; end
    chk("send_rdy", 64'(muldivreq_rdy), 64'd1);
    last_fn = fn; last_a = a; last_b = b;
    muldivreq_msg_fn = fn; muldivreq_msg_a = a; muldivreq_msg_b = b;
    muldivreq_val = 1'b1;
    acc = cyc;
    @(negedge clk);
    muldivreq_val = 1'b0;
  endtask

  task automatic push(input logic [31:0] res, input int lat);
    exp_t e;
    e.res = res; e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic wait_ops(input int n);
    int k = 0;
    while (ops_done != 16'(n) && k < 100) begin @(negedge clk); k++; end
    @(negedge clk);
    chk("ops_done", 64'(ops_done), 64'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc1, acc2, acc3, f0;
    repeat (3) @(negedge clk);
    chk("rst_muldivreq_rdy", 64'(muldivreq_rdy), 64'd1);
    chk("rst_divreq_val", 64'(divreq_val), 64'd0);
    chk("rst_muldivresp_val", 64'(muldivresp_val), 64'd0);
    chk("rst_divresp_rdy", 64'(divresp_rdy), 64'd1);
    chk("rst_ops_done", 64'(ops_done), 64'd0);
    chk("rst_result", 64'(muldivresp_msg_result), 64'd0);
    chk("rst_divreq_a", 64'(divreq_msg_a), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // DIVU 100/7
    push(32'd14, 3);
    send(2'd1, 32'd100, 32'd7, acc);
    wait_ops(1);

    // REM -7 % 2, signed request to divider
    push(32'hFFFF_FFFF, 3);
    send(2'd2, 32'hFFFF_FFF9, 32'd2, acc);
    chk("rem_divreq_fn", 64'(divreq_msg_fn), 64'd0);
    wait_ops(2);

    // Divide-by-zero bypass
    f0 = req_fires;
    push(32'hFFFF_FFFF, 1);
    send(2'd0, 32'd5, 32'd0, acc);
    push(32'd5, 1);
    send(2'd3, 32'd5, 32'd0, acc);
    wait_ops(4);
    chk("div0_no_divreq", 64'(req_fires - f0), 64'd0);

    // Backpressure on both sides
    f0 = req_fires;
    divreq_rdy = 1'b0;
    muldivresp_rdy = 1'b0;
    push(32'd100, -1);
    send(2'd1, 32'd1000, 32'd10, acc);
    for (int i = 0; i < 4; i++) begin
      chk("bp_divreq_val", 64'(divreq_val), 64'd1);
      chk("bp_divreq_a", 64'(divreq_msg_a), 64'd1000);
      chk("bp_divreq_b", 64'(divreq_msg_b), 64'd10);
      chk("bp_req_rdy", 64'(muldivreq_rdy), 64'd0);
      @(negedge clk);
    end
    divreq_rdy = 1'b1;
    for (int k = 0; k < 20 && !muldivresp_val; k++) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("bp_resp_val", 64'(muldivresp_val), 64'd1);
      chk("bp_resp_result", 64'(muldivresp_msg_result), 64'd100);
      chk("bp_req_rdy2", 64'(muldivreq_rdy), 64'd0);
      @(negedge clk);
    end
    muldivresp_rdy = 1'b1;
    @(negedge clk);
    chk("bp_req_rdy_after", 64'(muldivreq_rdy), 64'd1);
    chk("bp_one_divreq", 64'(req_fires - f0), 64'd1);
    chk("bp_ops_done", 64'(ops_done), 64'd5);

    // Reset while waiting on the divider; late response must be drained
    resp_delay = 2;
    send(2'd1, 32'd20, 32'd4, acc);
    @(negedge clk);
    chk("in_wait", 64'({divreq_val, muldivreq_rdy, muldivresp_val}), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("drain_rdy", 64'(divresp_rdy), 64'd1);
      chk("drain_no_resp", 64'(muldivresp_val), 64'd0);
      @(negedge clk);
    end
    chk("drain_done", 64'(divresp_val), 64'd0);
    chk("drain_ops_done", 64'(ops_done), 64'd0);
    resp_delay = 0;
    push(32'd3, 3);
    send(2'd1, 32'd9, 32'd3, acc);
    wait_ops(1);

    // Back-to-back requests with all readies high
    push(32'd10, 3);
    send(2'd1, 32'd50, 32'd5, acc1);
    push(32'hFFFF_FFFB, 3);
    send(2'd0, 32'hFFFF_FFEC, 32'd4, acc2);
    push(32'd2, 3);
    send(2'd3, 32'd17, 32'd5, acc3);
    chk("b2b_gap1", 64'(acc2 - acc1), 64'd4);
    chk("b2b_gap2", 64'(acc3 - acc2), 64'd4);
    wait_ops(4);

    // Signed overflow case passes through unchanged
    push(32'h8000_0000, 3);
    send(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, acc);
    wait_ops(5);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
